// File: rtl/control_unit.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/writeback for the supported subset
// and drives every datapath select, load enable and memory write from the current state.
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_overflow,
  input  logic       alu_eq,
  output logic       PC_write,
  output logic       wr,
  output logic       AB_load,
  output logic       aluout_load,
  output logic       EPC_load,
  output logic       sel_ir,
  output logic       regwrite,
  output logic       sel_alusrca,
  output logic [1:0] sel_alusrcb,
  output logic [2:0] sel_aluop,
  output logic [2:0] sel_pc_source,
  output logic [2:0] sel_mux_iord,
  output logic [1:0] sel_regdst,
  output logic [3:0] sel_mux_mem_to_reg,
  output logic       exc_cause,
  output logic [4:0] state
);

  typedef enum logic [4:0] {
    StReset     = 5'd0,
    StFetch     = 5'd1,
    StFetchWait = 5'd2,
    StDecode    = 5'd3,
    StRExec     = 5'd4,
    StRWb       = 5'd5,
    StSltExec   = 5'd6,
    StSltWb     = 5'd7,
    StJr        = 5'd8,
    StIExec     = 5'd9,
    StIWb       = 5'd10,
    StAddr      = 5'd11,
    StMemRd     = 5'd12,
    StMemWait   = 5'd13,
    StLwWb      = 5'd14,
    StMemWr     = 5'd15,
    StBranch    = 5'd16,
    StJump      = 5'd17,
    StJal1      = 5'd18,
    StJal2      = 5'd19,
    StExc1      = 5'd20,
    StExc2      = 5'd21
  } state_e;

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] FnJr    = 6'h08;
  localparam logic [5:0] FnAdd   = 6'h20;
  localparam logic [5:0] FnSub   = 6'h22;
  localparam logic [5:0] FnAnd   = 6'h24;
  localparam logic [5:0] FnSlt   = 6'h2A;

  state_e     r_state;
  logic       r_exc_cause;
  logic [2:0] w_r_aluop;
  logic       w_r_traps;
  logic       w_pc_write, w_wr, w_ab_load, w_aluout_load, w_epc_load, w_sel_ir, w_regwrite;

  always_comb begin
    w_r_aluop = 3'b001;
    unique case (funct)
      FnSub:   w_r_aluop = 3'b010;
      FnAnd:   w_r_aluop = 3'b011;
      default: w_r_aluop = 3'b001;
    endcase
  end

  // Only signed add/sub raise overflow; and ignores the flag.
  assign w_r_traps = (funct == FnAdd) || (funct == FnSub);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StReset;
      r_exc_cause <= 1'b0;
    end else begin
      r_exc_cause <= 1'b0;
      case (r_state)
        StReset:     r_state <= StFetch;
        StFetch:     r_state <= StFetchWait;
        StFetchWait: r_state <= StDecode;
        StDecode: begin
          case (opcode)
            OpRType: begin
              case (funct)
                FnAdd, FnSub, FnAnd: r_state <= StRExec;
                FnSlt:               r_state <= StSltExec;
                FnJr:                r_state <= StJr;
                default:             r_state <= StExc1;
              endcase
            end
            OpAddi:     r_state <= StIExec;
            OpLw, OpSw: r_state <= StAddr;
            OpBeq, OpBne: r_state <= StBranch;
            OpJ:        r_state <= StJump;
            OpJal:      r_state <= StJal1;
            default:    r_state <= StExc1;
          endcase
        end
        StRExec: begin
          if (alu_overflow && w_r_traps) begin
            r_state     <= StExc1;
            r_exc_cause <= 1'b1;
          end else begin
            r_state <= StRWb;
          end
        end
        StRWb:     r_state <= StFetch;
        StSltExec: r_state <= StSltWb;
        StSltWb:   r_state <= StFetch;
        StJr:      r_state <= StFetch;
        StIExec: begin
          if (alu_overflow) begin
            r_state     <= StExc1;
            r_exc_cause <= 1'b1;
          end else begin
            r_state <= StIWb;
          end
        end
        StIWb:     r_state <= StFetch;
        StAddr:    r_state <= (opcode == OpLw) ? StMemRd : StMemWr;
        StMemRd:   r_state <= StMemWait;
        StMemWait: r_state <= StLwWb;
        StLwWb:    r_state <= StFetch;
        StMemWr:   r_state <= StFetch;
        StBranch:  r_state <= StFetch;
        StJump:    r_state <= StFetch;
        StJal1:    r_state <= StJal2;
        StJal2:    r_state <= StFetch;
        StExc1: begin
          r_state     <= StExc2;
          r_exc_cause <= r_exc_cause;
        end
        StExc2:    r_state <= StFetch;
        default:   r_state <= StReset;
      endcase
    end
  end

  always_comb begin
    w_pc_write         = 1'b0;
    w_wr               = 1'b0;
    w_ab_load          = 1'b0;
    w_aluout_load      = 1'b0;
    w_epc_load         = 1'b0;
    w_sel_ir           = 1'b0;
    w_regwrite         = 1'b0;
    sel_alusrca        = 1'b0;
    sel_alusrcb        = 2'b00;
    sel_aluop          = 3'b000;
    sel_pc_source      = 3'b000;
    sel_mux_iord       = 3'b000;
    sel_regdst         = 2'b00;
    sel_mux_mem_to_reg = 4'b0000;
    case (r_state)
      StFetch: begin
        sel_alusrcb = 2'b01;
        sel_aluop   = 3'b001;
        w_pc_write  = 1'b1;
      end
      StFetchWait: w_sel_ir = 1'b1;
      StDecode: begin
        w_ab_load     = 1'b1;
        sel_alusrcb   = 2'b11;
        sel_aluop     = 3'b001;
        w_aluout_load = 1'b1;
      end
      StRExec: begin
        sel_alusrca   = 1'b1;
        sel_aluop     = w_r_aluop;
        w_aluout_load = 1'b1;
      end
      StRWb, StJal2, StSltWb, StIWb, StLwWb: begin
        w_regwrite = 1'b1;
        unique case (r_state)
          StRWb:   sel_regdst = 2'b01;
          StSltWb: begin
            sel_regdst         = 2'b01;
            sel_mux_mem_to_reg = 4'b0010;
            sel_aluop          = 3'b111;
          end
          StLwWb:  sel_mux_mem_to_reg = 4'b0001;
          StJal2: begin
            sel_regdst    = 2'b10;
            sel_pc_source = 3'b010;
            w_pc_write    = 1'b1;
          end
          default: sel_regdst = 2'b00;
        endcase
      end
      StSltExec: begin
        sel_alusrca = 1'b1;
        sel_aluop   = 3'b111;
      end
      StJr: begin
        sel_alusrca = 1'b1;
        w_pc_write  = 1'b1;
      end
      StIExec, StAddr: begin
        sel_alusrca   = 1'b1;
        sel_alusrcb   = 2'b10;
        sel_aluop     = 3'b001;
        w_aluout_load = 1'b1;
      end
      StMemRd, StMemWait: sel_mux_iord = 3'b001;
      StMemWr: begin
        sel_mux_iord = 3'b001;
        w_wr         = 1'b1;
      end
      StBranch: begin
        sel_alusrca   = 1'b1;
        sel_aluop     = 3'b111;
        sel_pc_source = 3'b001;
        w_pc_write    = (opcode == OpBeq) ? alu_eq : !alu_eq;
      end
      StJump: begin
        sel_pc_source = 3'b010;
        w_pc_write    = 1'b1;
      end
      StJal1: w_aluout_load = 1'b1;
      StExc1: begin
        sel_alusrcb = 2'b01;
        sel_aluop   = 3'b010;
        w_epc_load  = 1'b1;
      end
      StExc2: begin
        sel_pc_source = 3'b100;
        w_pc_write    = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are masked while reset is high so nothing commits in the cycle reset is raised.
  assign PC_write    = w_pc_write & ~reset;
  assign wr          = w_wr & ~reset;
  assign AB_load     = w_ab_load & ~reset;
  assign aluout_load = w_aluout_load & ~reset;
  assign EPC_load    = w_epc_load & ~reset;
  assign sel_ir      = w_sel_ir & ~reset;
  assign regwrite    = w_regwrite & ~reset;
  assign exc_cause   = r_exc_cause;
  assign state       = r_state;

endmodule

// File: doc/control_unit.md
# control_unit

Multicycle control FSM for the MIPS datapath; sits directly upstream of the datapath and drives every mux select, register load enable, memory write and ALU operation from the current opcode/funct and ALU flags. It implements fetch/decode/execute/writeback sequencing for the supported subset, including memory wait states and the opcode and overflow exception entry.

## Interface
- No parameters.
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-high; forces RESET state
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- alu_overflow  in  1  ula32 overflow flag
- alu_eq  in  1  ula32 equality flag
- PC_write, wr, AB_load, aluout_load, EPC_load, sel_ir, regwrite  out  1 each  load/write enables
- sel_alusrca  out  1  0=PC, 1=A
- sel_alusrcb  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- sel_aluop  out  3  ula32 code: 000 pass A, 001 add, 010 sub, 011 and, 111 compare
- sel_pc_source  out  3  000=ALU result, 001=ALUOut, 010=jump target, 100=exception vector
- sel_mux_iord  out  3  000=PC, 001=ALUOut
- sel_regdst  out  2  00=rt, 01=rd, 10=$31
- sel_mux_mem_to_reg  out  4  0000=ALUOut, 0001=memory data, 0010=lt_extended
- exc_cause  out  1  0=illegal opcode vector, 1=overflow vector; valid while sel_pc_source=100
- state  out  5  current state encoding, for verification

## Operation
- Every output is 0 in any state unless listed; outputs are a pure function of state (plus alu_eq/opcode for branch PC_write).
- RESET: all outputs 0 -> FETCH.
- FETCH: iord 000, srca 0, srcb 01, aluop 001, pc_source 000, PC_write -> FETCH_WAIT.
- FETCH_WAIT: sel_ir=1 (memory data valid one cycle after address) -> DECODE.
- DECODE: AB_load; srca 0, srcb 11, aluop 001, aluout_load (branch target). Dispatch on opcode:
  - 0x00 funct 0x20/0x22/0x24 -> R_EXEC (aluop 001/010/011); 0x2A -> SLT_EXEC; 0x08 -> JR; other funct -> EXC1 cause 0.
  - 0x08 addi -> I_EXEC; 0x23 lw / 0x2B sw -> ADDR; 0x04 beq / 0x05 bne -> BRANCH; 0x02 -> JUMP; 0x03 -> JAL1; anything else -> EXC1 cause 0.
- R_EXEC: srca 1, srcb 00, aluop per funct, aluout_load. If alu_overflow and funct in {0x20,0x22} -> EXC1 cause 1, else -> R_WB.
- R_WB: regdst 01, mem_to_reg 0000, regwrite -> FETCH.
- SLT_EXEC: srca 1, srcb 00, aluop 111 -> SLT_WB: regdst 01, mem_to_reg 0010, aluop held 111, regwrite -> FETCH.
- JR: srca 1, aluop 000, pc_source 000, PC_write -> FETCH.
- I_EXEC: srca 1, srcb 10, aluop 001, aluout_load; overflow -> EXC1 cause 1, else -> I_WB (regdst 00, mem_to_reg 0000, regwrite) -> FETCH.
- ADDR: srca 1, srcb 10, aluop 001, aluout_load -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: iord 001 -> MEM_WAIT: iord 001 -> LW_WB: regdst 00, mem_to_reg 0001, regwrite -> FETCH.
- MEM_WR: iord 001, wr -> FETCH.
- BRANCH: srca 1, srcb 00, aluop 111, pc_source 001; PC_write = alu_eq (beq) or !alu_eq (bne) -> FETCH.
- JUMP: pc_source 010, PC_write -> FETCH.
- JAL1: srca 0, aluop 000, aluout_load (PC+4) -> JAL2: regdst 10, mem_to_reg 0000, regwrite, pc_source 010, PC_write -> FETCH.
- EXC1: srca 0, srcb 01, aluop 010 (PC-4), EPC_load -> EXC2: pc_source 100, PC_write, exc_cause held -> FETCH. regwrite never asserted on an excepting instruction.

## Timing
- Latency in cycles (FETCH to next FETCH): R-type/slt/addi 5, lw 7, sw 5, beq/bne/j/jr 4, jal 5, exception 5 (from FETCH).
- wr and regwrite are high for exactly one cycle per instruction; never both in the same cycle.
- reset sampled at rising edge: reset high at any state -> RESET next edge, outputs 0 from that edge; no write enable asserted while reset is high; FETCH follows the first edge with reset low.
- exc_cause registered at EXC1 entry, stable through EXC2; 0 otherwise.

## Test plan
- Reset held 3 cycles then released -> all outputs 0 during reset, state RESET then FETCH; PC_write=1 in FETCH.
- opcode 0x00 funct 0x20, alu_overflow 0 -> states FETCH,FETCH_WAIT,DECODE,R_EXEC,R_WB; regwrite=1 only in R_WB with regdst 01.
- opcode 0x23 -> 7 cycles; iord 001 in MEM_RD and MEM_WAIT; regwrite with mem_to_reg 0001 in LW_WB.
- opcode 0x04 with alu_eq 1 -> PC_write=1, pc_source 001 in BRANCH; alu_eq 0 -> PC_write=0; opcode 0x05 inverse.
- opcode 0x3F -> EXC1 (EPC_load, aluop 010), EXC2 (pc_source 100, exc_cause 0); addi with alu_overflow 1 in I_EXEC -> exc_cause 1, regwrite never high.
- reset asserted during MEM_WR-preceding ADDR state -> next edge RESET, wr never asserted.
